// File: rtl/aes_dec_kat_seq.sv
// Known-answer test sequencer for an external AES decrypt core.
// Drives the FIPS-197 Appendix C ciphertext/key for the configured key size,
// waits for the core result and compares it with the expected plaintext.
// Optional feature macro: AES_DEC_TIMEOUT_EN (bounded wait with timeout flag).
module aes_dec_kat_seq #(
  parameter int unsigned Nk             = 4,
  parameter int unsigned Nr             = Nk + 6,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [127:0]    dec_ct,
  output logic [32*Nk-1:0] dec_key,
  output logic            dec_load,
  input  logic [127:0]    dec_pt,
  input  logic            dec_valid,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [7:0]      pass_cnt
);

  // Reject illegal configurations at elaboration time.
  if (!(Nk == 4 || Nk == 6 || Nk == 8) || Nr != Nk + 6 ||
      TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("aes_dec_kat_seq: illegal Nk/Nr/TIMEOUT_CYCLES");
  end

  // Key bytes 00,01,... MSB first.
  function automatic logic [32*Nk-1:0] gen_key();
    logic [32*Nk-1:0] k;
    k = '0;
    for (int i = 0; i < 4 * Nk; i++) begin
      k[32*Nk-1-8*i -: 8] = 8'(i);
    end
    return k;
  endfunction

  localparam logic [127:0] PtExp = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtVec =
      (Nk == 8) ? 128'h8ea2b7ca516745bfeafc49904b496089 :
      (Nk == 6) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [32*Nk-1:0] KeyVec = gen_key();

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StDone} state_e;

  state_e     state_q, state_d;
  logic       start_q, rise_q;
  logic       valid_q, match_q;
  logic       seen_low_q, seen_low_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic       qualify;

`ifdef AES_DEC_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  assign dec_ct   = CtVec;
  assign dec_key  = KeyVec;
  // All outputs decode registered state only.
  assign dec_load = (state_q == StLoad);
  assign busy     = (state_q == StLoad) || (state_q == StWait);
  assign done     = (state_q == StDone);
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign pass_cnt = pass_cnt_q;
`ifdef AES_DEC_TIMEOUT_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

  // Result is qualified only after a low valid has been seen this run.
  assign qualify = valid_q & seen_low_q;

  // Next-state and flag updates.
  always_comb begin
    state_d    = state_q;
    seen_low_d = seen_low_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    pass_cnt_d = pass_cnt_q;
`ifdef AES_DEC_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      StIdle: begin
        if (rise_q) begin
          pass_d  = 1'b0;
          fail_d  = 1'b0;
`ifdef AES_DEC_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = StLoad;
        end
      end
      StLoad: begin
        seen_low_d = 1'b0;
`ifdef AES_DEC_TIMEOUT_EN
        cnt_d      = '0;
`endif
        state_d    = StWait;
      end
      StWait: begin
        seen_low_d = seen_low_q | ~valid_q;
        // A qualifying result takes priority over the timeout.
        if (qualify) begin
          if (match_q) begin
            pass_d     = 1'b1;
            pass_cnt_d = (pass_cnt_q == 8'hff) ? pass_cnt_q : pass_cnt_q + 8'd1;
          end else begin
            fail_d = 1'b1;
          end
          state_d = StDone;
        end
`ifdef AES_DEC_TIMEOUT_EN
        else if (cnt_q == TmoLast) begin
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      StDone: begin
        if (!start_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, input capture and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      start_q    <= 1'b0;
      rise_q     <= 1'b0;
      valid_q    <= 1'b0;
      match_q    <= 1'b0;
      seen_low_q <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pass_cnt_q <= 8'd0;
`ifdef AES_DEC_TIMEOUT_EN
      cnt_q      <= 16'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      rise_q     <= start & ~start_q;
      valid_q    <= dec_valid;
      match_q    <= (dec_pt == PtExp);
      seen_low_q <= seen_low_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
`ifdef AES_DEC_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

endmodule

// File: doc/aes_dec_kat_seq.md
# aes_dec_kat_seq

Known-answer test sequencer for the AES decrypt datapath. On a start request it drives the FIPS-197 Appendix C ciphertext and key for the configured key size into an external `aes_decrypt` core, waits for the core's result, and compares it with the expected plaintext. Pass/fail, busy/done and a saturating pass counter go to board LEDs, so decryption can be checked on hardware the same way encryption already is.

## Interface
- `Nk`, default 4: key length in 32-bit words; legal values are 4, 6 and 8.
- `Nr`, default `Nk + 6`: round count; passed through for documentation only, no logic uses it.
- `TIMEOUT_CYCLES`, default 1024: maximum number of cycles spent in WAIT; legal range is 16..65535.
- `clk` input, 1: single clock for the block.
- `rst` input, 1: synchronous, active-high reset.
- `start` input, 1: level input (for example a switch); a rising edge requests one run.
- `dec_ct` output, 128: ciphertext driven to the core.
- `dec_key` output, `32*Nk`: cipher key driven to the core.
- `dec_load` output, 1: one-cycle load pulse to the core.
- `dec_pt` input, 128: plaintext returned by the core.
- `dec_valid` input, 1: core result-valid flag.
- `busy` output, 1: high while in LOAD or WAIT.
- `done` output, 1: high while in DONE.
- `pass` output, 1: sticky; set when the last run matched.
- `fail` output, 1: sticky; set when the last run mismatched or timed out.
- `timeout` output, 1: sticky; set when the last run ended by timeout.
- `pass_cnt` output, 8: number of passing runs, saturates at 255.

## Operation
- Vectors are constants selected by `Nk`:
  - Expected plaintext for all key sizes: 00112233445566778899aabbccddeeff.
  - Key: bytes 00,01,…,(4·Nk−1), MSB first.
  - `Nk`=4: ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `Nk`=6: ct dda97ca4864cdfe06eaf70a0ec0d7191.
  - `Nk`=8: ct 8ea2b7ca516745bfeafc49904b496089.
- `dec_ct` and `dec_key` are driven with these constants at all times, including during reset.
- `start` is registered once into `start_q`. A rise is the condition `start & ~start_q`.
- FSM state IDLE:
  - On a rise, clear `pass`, `fail` and `timeout`, then go to LOAD.
  - With no rise, stay in IDLE.
- FSM state LOAD:
  - Lasts exactly 1 cycle with `dec_load`=1.
  - Clears `seen_low`, clears the wait counter, then goes to WAIT.
- FSM state WAIT:
  - `seen_low` is set the first cycle `dec_valid`=0 is observed. This rejects a valid flag left high from the previous run.
  - When `dec_valid`=1 and `seen_low`=1, compare `dec_pt` with the expected plaintext in that cycle.
    - Match: set `pass` and increment `pass_cnt` (saturating at 255).
    - Mismatch: set `fail`.
    - Either way, go to DONE.
- FSM state DONE:
  - Hold all flags.
  - Return to IDLE once `start_q`=0, so one switch-up produces exactly one run.
- `start` rises are ignored in LOAD, WAIT and DONE.
- `dec_valid` is ignored in IDLE, LOAD and DONE.
- `pass` and `fail` are never high together.

## Timing
- Reset, checked at a rising clock edge with `rst`=1, sets:
  - state to IDLE;
  - `start_q`, `dec_load`, `busy`, `done`, `pass`, `fail`, `timeout` to 0;
  - `pass_cnt` to 0.
- `rst` overrides every other event. A run interrupted by reset is abandoned, and no `dec_load` is issued afterwards.
- Run timeline, with `start` rising before edge N:
  - Edge N: `start_q`=1 and the rise is detected.
  - Edge N+1: state is LOAD and `dec_load`=1.
  - Edge N+2: state is WAIT and `dec_load`=0.
- Result timing: if `dec_valid` qualifies at edge M, then `done`, `pass`/`fail` and `pass_cnt` are updated at edge M+1.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `AES_DEC_TIMEOUT_EN` defined:
  - WAIT increments a 16-bit counter every cycle.
  - If the counter reaches `TIMEOUT_CYCLES` without a qualifying `dec_valid`, set `fail` and `timeout` and go to DONE.
  - If a qualifying `dec_valid` arrives in the same cycle the counter reaches the limit, the valid wins.
- `AES_DEC_TIMEOUT_EN` undefined:
  - No counter; WAIT waits indefinitely.
  - `timeout` is tied to 0.

## Test plan
1. Correct result:
   - Stimulus: `Nk`=4; model raises `dec_valid` with pt 00112233445566778899aabbccddeeff 12 cycles after `dec_load`.
   - Required: `dec_load` is a single pulse 2 cycles after the `start` rise, then `pass`=1, `done`=1, `pass_cnt`=1.
2. Wrong result:
   - Stimulus: model returns pt with bit 0 flipped.
   - Required: `fail`=1, `pass`=0, `pass_cnt` unchanged.
3. Stale valid:
   - Stimulus: `dec_valid` held at 1 through LOAD and for 3 WAIT cycles, then 0 for 2 cycles, then 1 with the correct pt.
   - Required: the check happens only on the second high; `pass`=1.
4. Timeout:
   - Stimulus: with `AES_DEC_TIMEOUT_EN` and `TIMEOUT_CYCLES`=32, `dec_valid` is never asserted.
   - Required: `fail`=1 and `timeout`=1 exactly 32 cycles after entering WAIT.
   - Without the macro, the block is still busy after 5000 cycles.
5. Reset mid-run:
   - Stimulus: assert `rst` in WAIT.
   - Required: all outputs are 0 at the next edge and no further `dec_load` appears.
   - Then toggle `start` 300 times with correct responses: `pass_cnt` saturates at 255.
6. Other key sizes:
   - Stimulus: `Nk`=6 and `Nk`=8.
   - Required: `dec_ct` and `dec_key` equal the vectors above; a correct model response yields `pass`=1.
